// File: rtl/milano_pkg.sv
// Shared types for the milano core's load/store path: access size, LSU FSM states
// and the byte-enable / store-lane helpers.
package milano_pkg;

    typedef enum logic [1:0] {
        LSU_BYTE = 2'b00,
        LSU_HALF = 2'b01,
        LSU_WORD = 2'b10
    } lsu_type_e;

    typedef enum logic [1:0] {
        IDLE        = 2'b00,
        WAIT_GNT    = 2'b01,
        WAIT_RVALID = 2'b10
    } lsu_state_e;

    function automatic logic [3:0] lsu_be(input lsu_type_e t, input logic [1:0] off);
        case (t)
            LSU_BYTE: return 4'b0001 << off;
            LSU_HALF: return 4'b0011 << {off[1], 1'b0};
            default:  return 4'b1111;
        endcase
    endfunction

    // The bus picks the addressed lane with byte enables, so every lane carries the data.
    function automatic logic [31:0] lsu_lanes(input lsu_type_e t, input logic [31:0] wdata);
        case (t)
            LSU_BYTE: return {4{wdata[7:0]}};
            LSU_HALF: return {2{wdata[15:0]}};
            default:  return wdata;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Extracts the addressed byte/half/word from a bus read word and sign- or
// zero-extends it to 32 bits.
module lsu_load_align
    import milano_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  off_i,
    input  lsu_type_e   type_i,
    input  logic        sign_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;

    assign shifted = rdata_i >> {off_i, 3'b000};

    always_comb begin
        case (type_i)
            LSU_BYTE: data_o = {{24{sign_i & shifted[7]}}, shifted[7:0]};
            LSU_HALF: data_o = {{16{sign_i & shifted[15]}}, shifted[15:0]};
            default:  data_o = shifted;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// milano EX-stage load/store unit: one req/gnt/rvalid bus transaction at a time.
// Optional LSU_MISALIGN_TRAP_EN rejects misaligned HALF/WORD accesses with lsu_err_o.
module lsu
    import milano_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  lsu_type_e   lsu_type_i,
    input  logic        lsu_sign_ext_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    input  logic [4:0]  rd_addr_i,
    output logic        lsu_busy_o,
    output logic        lsu_err_o,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic [31:0] data_rdata_i,
    output logic        reg_we_o,
    output logic [4:0]  wr_addr_o,
    output logic [31:0] rd_wdata_o
);

    lsu_state_e  state_q, state_d;
    lsu_type_e   type_d, type_q;
    logic [31:0] addr_q, wdata_q;
    logic        we_q, sign_q;
    logic [4:0]  rd_q;
    logic        reg_we_q, reg_we_d;
    logic [31:0] rd_wdata_q;
    logic [31:0] load_val;
    logic        misalign;
    logic        accept;
    logic        resp;

    // Reserved encoding 2'b11 behaves as WORD.
    assign type_d = (lsu_type_i == LSU_BYTE || lsu_type_i == LSU_HALF) ? lsu_type_i : LSU_WORD;

`ifdef LSU_MISALIGN_TRAP_EN
    logic err_q;
    assign misalign = (type_d == LSU_HALF && lsu_addr_i[0]) ||
                      (type_d == LSU_WORD && lsu_addr_i[1:0] != 2'b00);
    always_ff @(posedge clk_i) begin
        if (!rst_ni) err_q <= 1'b0;
        else         err_q <= (state_q == IDLE) && lsu_req_i && misalign;
    end
    assign lsu_err_o = err_q;
`else
    assign misalign  = 1'b0;
    assign lsu_err_o = 1'b0;
`endif

    assign accept = (state_q == IDLE) && lsu_req_i && !misalign;
    assign resp   = (state_q == WAIT_RVALID) && data_rvalid_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:        if (accept)        state_d = WAIT_GNT;
            WAIT_GNT:    if (data_gnt_i)    state_d = WAIT_RVALID;
            WAIT_RVALID: if (data_rvalid_i) state_d = IDLE;
            default:                        state_d = IDLE;
        endcase
    end

    always_comb begin
        lsu_busy_o   = (state_q != IDLE);
        data_req_o   = (state_q == WAIT_GNT);
        data_addr_o  = 32'h0;
        data_we_o    = 1'b0;
        data_be_o    = 4'h0;
        data_wdata_o = 32'h0;
        if (state_q != IDLE) begin
            data_addr_o  = {addr_q[31:2], 2'b00};
            data_we_o    = we_q;
            data_be_o    = lsu_be(type_q, addr_q[1:0]);
            data_wdata_o = lsu_lanes(type_q, wdata_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            addr_q  <= 32'h0;
            type_q  <= LSU_BYTE;
            sign_q  <= 1'b0;
            we_q    <= 1'b0;
            wdata_q <= 32'h0;
            rd_q    <= 5'd0;
        end else if (accept) begin
            addr_q  <= lsu_addr_i;
            type_q  <= type_d;
            sign_q  <= lsu_sign_ext_i;
            we_q    <= lsu_we_i;
            wdata_q <= lsu_wdata_i;
            rd_q    <= rd_addr_i;
        end
    end

    lsu_load_align u_align (
        .rdata_i (data_rdata_i),
        .off_i   (addr_q[1:0]),
        .type_i  (type_q),
        .sign_i  (sign_q),
        .data_o  (load_val)
    );

    // x0 is hardwired, so loads into it complete on the bus but never write back.
    assign reg_we_d = resp && !we_q && (rd_q != 5'd0);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            reg_we_q   <= 1'b0;
            rd_wdata_q <= 32'h0;
        end else begin
            reg_we_q <= reg_we_d;
            if (reg_we_d) rd_wdata_q <= load_val;
        end
    end

    assign reg_we_o   = reg_we_q;
    assign wr_addr_o  = rd_q;
    assign rd_wdata_o = rd_wdata_q;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: vector table of bus accesses plus hand sequences for reset,
// back-to-back and misalignment; register writes checked through a scoreboard queue.
module tb_lsu;
    import milano_pkg::*;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        lsu_req_i, lsu_we_i, lsu_sign_ext_i;
    lsu_type_e   lsu_type_i;
    logic [31:0] lsu_addr_i, lsu_wdata_i;
    logic [4:0]  rd_addr_i;
    logic        lsu_busy_o, lsu_err_o;
    logic        data_req_o, data_gnt_i, data_rvalid_i, data_we_o;
    logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;
    logic [3:0]  data_be_o;
    logic        reg_we_o;
    logic [4:0]  wr_addr_o;
    logic [31:0] rd_wdata_o;

    always #5 clk = ~clk;

    lsu dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .lsu_req_i      (lsu_req_i),
        .lsu_we_i       (lsu_we_i),
        .lsu_type_i     (lsu_type_i),
        .lsu_sign_ext_i (lsu_sign_ext_i),
        .lsu_addr_i     (lsu_addr_i),
        .lsu_wdata_i    (lsu_wdata_i),
        .rd_addr_i      (rd_addr_i),
        .lsu_busy_o     (lsu_busy_o),
        .lsu_err_o      (lsu_err_o),
        .data_req_o     (data_req_o),
        .data_gnt_i     (data_gnt_i),
        .data_rvalid_i  (data_rvalid_i),
        .data_addr_o    (data_addr_o),
        .data_we_o      (data_we_o),
        .data_be_o      (data_be_o),
        .data_wdata_o   (data_wdata_o),
        .data_rdata_i   (data_rdata_i),
        .reg_we_o       (reg_we_o),
        .wr_addr_o      (wr_addr_o),
        .rd_wdata_o     (rd_wdata_o)
    );

    typedef struct {
        logic        we;
        logic [1:0]  typ;
        logic        sext;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [4:0]  rd;
        int          gnt_dly;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic        exp_wr;
        logic [31:0] exp_val;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    logic [36:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every register write must match the oldest expected write.
    always @(negedge clk) begin
        logic [36:0] e;
        if (reg_we_o === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_reg_write: got rd=%0d data=%h, expected no write", wr_addr_o, rd_wdata_o);
            end else begin
                e = exp_q.pop_front();
                if ({wr_addr_o, rd_wdata_o} !== e) begin
                    n_fail++;
                    $display("FAIL reg_write: got rd=%0d data=%h, expected rd=%0d data=%h",
                             wr_addr_o, rd_wdata_o, e[36:32], e[31:0]);
                end
            end
        end
    end

    task automatic idle_inputs();
        lsu_req_i      = 1'b0;
        lsu_we_i       = 1'b0;
        lsu_type_i     = LSU_BYTE;
        lsu_sign_ext_i = 1'b0;
        lsu_addr_i     = 32'h0;
        lsu_wdata_i    = 32'h0;
        rd_addr_i      = 5'd0;
        data_gnt_i     = 1'b0;
        data_rvalid_i  = 1'b0;
        data_rdata_i   = 32'h0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},  {31'b0, lsu_busy_o}, 32'h0);
        check({tag, "_req"},   {31'b0, data_req_o}, 32'h0);
        check({tag, "_addr"},  data_addr_o, 32'h0);
        check({tag, "_be"},    {28'b0, data_be_o}, 32'h0);
        check({tag, "_wdata"}, data_wdata_o, 32'h0);
        check({tag, "_we"},    {31'b0, data_we_o}, 32'h0);
        check({tag, "_regwe"}, {31'b0, reg_we_o}, 32'h0);
    endtask

    // Entered and left at posedge+1; leaves at the cycle lsu_busy_o has fallen.
    task automatic run_vec(input vec_t v, input bit poke);
        lsu_req_i      = 1'b1;
        lsu_we_i       = v.we;
        lsu_type_i     = lsu_type_e'(v.typ);
        lsu_sign_ext_i = v.sext;
        lsu_addr_i     = v.addr;
        lsu_wdata_i    = v.wdata;
        rd_addr_i      = v.rd;
        @(posedge clk); #1;
        lsu_req_i   = 1'b0;
        lsu_addr_i  = 32'hFFFF_FFFF;
        lsu_wdata_i = 32'h5555_5555;
        lsu_we_i    = ~v.we;
        rd_addr_i   = 5'd31;
        if (v.exp_wr) exp_q.push_back({v.rd, v.exp_val});
        for (int i = 0; i <= v.gnt_dly; i++) begin
            check("bus_req",   {31'b0, data_req_o}, 32'h1);
            check("busy",      {31'b0, lsu_busy_o}, 32'h1);
            check("bus_addr",  data_addr_o, v.exp_addr);
            check("bus_be",    {28'b0, data_be_o}, {28'b0, v.exp_be});
            check("bus_wdata", data_wdata_o, v.exp_wdata);
            check("bus_we",    {31'b0, data_we_o}, {31'b0, v.we});
            lsu_req_i  = poke && (i == 0);
            lsu_addr_i = 32'h0000_0FF0;
            data_gnt_i = (i == v.gnt_dly);
            @(posedge clk); #1;
            data_gnt_i = 1'b0;
            lsu_req_i  = 1'b0;
        end
        check("wait_rvalid_req",  {31'b0, data_req_o}, 32'h0);
        check("wait_rvalid_busy", {31'b0, lsu_busy_o}, 32'h1);
        data_rvalid_i = 1'b1;
        data_rdata_i  = v.rdata;
        @(posedge clk); #1;
        data_rvalid_i = 1'b0;
        data_rdata_i  = $urandom;
        check("done_busy",  {31'b0, lsu_busy_o}, 32'h0);
        check("done_be",    {28'b0, data_be_o}, 32'h0);
        check("done_reg_we", {31'b0, reg_we_o}, {31'b0, v.exp_wr});
    endtask

    vec_t vecs[12];
    vec_t r;

    initial begin
        //            we    typ    sx    addr          wdata         rdata         rd   dly  exp_addr      be       exp_wdata     wr    val
        vecs[0]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 5'd5,  0, 32'h0000_0100, 4'hF,    32'h0,        1'b1, 32'hDEAD_BEEF};
        vecs[1]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0203, 32'h0,        32'h8011_2233, 5'd6,  0, 32'h0000_0200, 4'b1000, 32'h0,        1'b1, 32'hFFFF_FF80};
        vecs[2]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0203, 32'h0,        32'h8011_2233, 5'd7,  1, 32'h0000_0200, 4'b1000, 32'h0,        1'b1, 32'h0000_0080};
        vecs[3]  = '{1'b1, 2'b01, 1'b0, 32'h0000_0302, 32'h0000_ABCD, 32'h0,        5'd9,  3, 32'h0000_0300, 4'b1100, 32'hABCD_ABCD, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0,        32'h8001_1234, 5'd8,  0, 32'h0000_0100, 4'b1100, 32'h0,        1'b1, 32'hFFFF_8001};
        vecs[5]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0100, 32'h0,        32'h8001_F234, 5'd9,  2, 32'h0000_0100, 4'b0011, 32'h0,        1'b1, 32'h0000_F234};
        vecs[6]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0,        32'h1234_5678, 5'd0,  0, 32'h0000_0400, 4'hF,    32'h0,        1'b0, 32'h0};
        vecs[7]  = '{1'b1, 2'b00, 1'b0, 32'h0000_0001, 32'h1234_56A5, 32'h0,        5'd3,  1, 32'h0000_0000, 4'b0010, 32'hA5A5_A5A5, 1'b0, 32'h0};
        vecs[8]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0204, 32'hCAFE_F00D, 32'h0,        5'd4,  0, 32'h0000_0204, 4'hF,    32'hCAFE_F00D, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 2'b11, 1'b1, 32'h0000_0040, 32'h0,        32'h1122_3344, 5'd10, 0, 32'h0000_0040, 4'hF,    32'h0,        1'b1, 32'h1122_3344};
        vecs[10] = '{1'b0, 2'b00, 1'b1, 32'h0000_0201, 32'h0,        32'h0000_7F00, 5'd11, 0, 32'h0000_0200, 4'b0010, 32'h0,        1'b1, 32'h0000_007F};
        vecs[11] = '{1'b1, 2'b01, 1'b0, 32'h0000_0010, 32'hFFFF_8421, 32'h0,        5'd1,  0, 32'h0000_0010, 4'b0011, 32'h8421_8421, 1'b0, 32'h0};

        idle_inputs();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        check("reset_err", {31'b0, lsu_err_o}, 32'h0);
        rst_ni = 1'b1;
        @(posedge clk); #1;

        // Calls run back to back: each new req lands on the cycle busy falls.
        for (int i = 0; i < 12; i++) run_vec(vecs[i], (i == 3) || (i == 5));

        for (int i = 0; i < 8; i++) begin
            r = '{1'b0, 2'b10, 1'b0, {$urandom, 2'b00} & 32'hFFFF_FFFC, 32'h0, $urandom,
                  5'($urandom_range(1, 31)), $urandom_range(0, 2), 32'h0, 4'hF, 32'h0, 1'b1, 32'h0};
            r.exp_addr = r.addr;
            r.exp_val  = r.rdata;
            run_vec(r, 1'b0);
        end

        // Misaligned word load.
`ifdef LSU_MISALIGN_TRAP_EN
        lsu_req_i  = 1'b1;
        lsu_we_i   = 1'b0;
        lsu_type_i = LSU_WORD;
        lsu_addr_i = 32'h0000_0102;
        rd_addr_i  = 5'd12;
        @(posedge clk); #1;
        lsu_req_i = 1'b0;
        check("misalign_err",  {31'b0, lsu_err_o}, 32'h1);
        check("misalign_req",  {31'b0, data_req_o}, 32'h0);
        check("misalign_busy", {31'b0, lsu_busy_o}, 32'h0);
        @(posedge clk); #1;
        check("misalign_err_pulse", {31'b0, lsu_err_o}, 32'h0);
        check("misalign_req_after", {31'b0, data_req_o}, 32'h0);
`else
        r = '{1'b0, 2'b10, 1'b0, 32'h0000_0102, 32'h0, 32'h1122_3344, 5'd12, 0,
              32'h0000_0100, 4'hF, 32'h0, 1'b1, 32'h0000_1122};
        run_vec(r, 1'b0);
        check("misalign_no_err", {31'b0, lsu_err_o}, 32'h0);
`endif

        // Reset while waiting for rvalid; the late rvalid must be dropped.
        idle_inputs();
        lsu_req_i  = 1'b1;
        lsu_type_i = LSU_WORD;
        lsu_addr_i = 32'h0000_0080;
        rd_addr_i  = 5'd13;
        @(posedge clk); #1;
        lsu_req_i  = 1'b0;
        data_gnt_i = 1'b1;
        @(posedge clk); #1;
        data_gnt_i = 1'b0;
        check("rst_mid_busy", {31'b0, lsu_busy_o}, 32'h1);
        rst_ni = 1'b0;
        @(posedge clk); #1;
        rst_ni = 1'b1;
        check_idle_outputs("rst_mid");
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'hBAD0_BAD0;
        @(posedge clk); #1;
        data_rvalid_i = 1'b0;
        check_idle_outputs("late_rvalid");
        check("late_rvalid_wraddr", {27'b0, wr_addr_o}, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", exp_q.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "timeout");
    end

endmodule
